logic_gate_unit: RTL and testbench

LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

---
 rtl/logic_gate_unit.sv | 168 ++++++++++++++++
 tb/tb_logic_gate_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered bitwise logic unit with a valid/ready operand
// port, a one-deep result register, and a built-in exhaustive truth-table
// sweep that walks every {a, b} combination through the selected operation.
module logic_gate_unit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             all_ones,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int VW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               all_ones_q, all_ones_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [2:0]         sweep_op_q, sweep_op_d;
  logic [VW-1:0]      vec_q, vec_d;
  // Set once the all-ones vector has been loaded; the result register then
  // holds the final sweep result until it is delivered.
  logic               last_q, last_d;

  logic               deliver;
  logic               out_free;
  logic               load_in;
  logic               load_vec;
  logic               sweep_go;
  logic [2:0]         op_sel;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [WIDTH-1:0]   res;

  // Bitwise operation table; NOT and pass use only the a operand.
  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] o,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (o)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = x ^ y;
      3'b011:  r = ~(x ^ y);
      3'b100:  r = ~(x & y);
      3'b101:  r = ~(x | y);
      3'b110:  r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  // State register and all datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      s_q         <= '0;
      all_ones_q  <= 1'b0;
      out_valid_q <= 1'b0;
      match_cnt_q <= '0;
      sweep_op_q  <= 3'b000;
      vec_q       <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      all_ones_q  <= all_ones_d;
      out_valid_q <= out_valid_d;
      match_cnt_q <= match_cnt_d;
      sweep_op_q  <= sweep_op_d;
      vec_q       <= vec_d;
      last_q      <= last_d;
    end
  end

  // Next-state logic: leave SWEEP only when the final vector's result is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sweep_start) state_d = SWEEP;
      SWEEP:   if (last_q && deliver) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
    sweep_busy = (state_q == SWEEP) || (state_q == DONE);
    sweep_done = (state_q == DONE);
  end

  // Result register, sweep vector and match counter next-state.
  always_comb begin
    deliver  = out_valid_q && out_ready;
    out_free = !out_valid_q || out_ready;
    load_in  = in_valid && in_ready;
    load_vec = (state_q == SWEEP) && !last_q && out_free;
    sweep_go = (state_q == IDLE) && sweep_start;

    if (load_vec) begin
      op_sel = sweep_op_q;
      a_sel  = vec_q[VW-1:WIDTH];
      b_sel  = vec_q[WIDTH-1:0];
    end else begin
      op_sel = op;
      a_sel  = a;
      b_sel  = b;
    end
    res = logic_op(op_sel, a_sel, b_sel);

    s_d         = s_q;
    all_ones_d  = all_ones_q;
    out_valid_d = out_valid_q;
    if (load_in || load_vec) begin
      s_d         = res;
      all_ones_d  = &res;
      out_valid_d = 1'b1;
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end

    sweep_op_d = sweep_op_q;
    vec_d      = vec_q;
    last_d     = last_q;
    if (sweep_go) begin
      sweep_op_d = op;
      vec_d      = '0;
      last_d     = 1'b0;
    end else if (load_vec) begin
      vec_d = vec_q + VW'(1);
      if (&vec_q) last_d = 1'b1;
    end

    match_cnt_d = match_cnt_q;
    if (sweep_go) begin
      match_cnt_d = '0;
    end else if (deliver && all_ones_q && !(&match_cnt_q)) begin
      match_cnt_d = match_cnt_q + CNT_W'(1);
    end
  end

  assign s         = s_q;
  assign all_ones  = all_ones_q;
  assign out_valid = out_valid_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: a negedge monitor pushes expected
// results into a scoreboard on every accepted beat or sweep start and pops
// them on every delivery; match_cnt is tracked by an independent model.
module tb_logic_gate_unit;

  localparam int W  = 4;
  localparam int CW = 5;
  localparam int NV = 1 << (2 * W);
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          in_valid, in_ready;
  logic [W-1:0]  s;
  logic          out_valid, out_ready;
  logic          all_ones;
  logic          sweep_start, sweep_busy, sweep_done;
  logic [CW-1:0] match_cnt;

  logic_gate_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .op(op), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .out_valid(out_valid), .out_ready(out_ready),
    .all_ones(all_ones), .sweep_start(sweep_start),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .match_cnt(match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x ^ y);
      3'd4:    return ~(x & y);
      3'd5:    return ~(x | y);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  logic [W:0] sb_q[$];
  int  mcnt = 0;
  int  done_cnt = 0;
  bit  sw_eff = 0;
  bit  chk_busy_ready = 0;

  // Monitor: sampled mid-cycle, describes what the next rising edge will do.
  always @(negedge clk) begin
    logic [W-1:0]   r;
    logic [W:0]     e;
    logic [2*W-1:0] vv;
    check_eq("match_cnt", match_cnt, mcnt);
    if (reset) begin
      sb_q.delete();
      mcnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        check_eq("sb_nonempty_at_delivery", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_eq("result_s", s, e[W-1:0]);
          check_eq("result_all_ones", all_ones, e[W]);
          if (e[W] && mcnt < CMAX) mcnt++;
        end
      end
      if (in_valid && in_ready) begin
        r = ref_op(op, a, b);
        sb_q.push_back({&r, r});
      end
      if (sweep_start && sw_eff) begin
        mcnt = 0;
        for (int v = 0; v < NV; v++) begin
          vv = (2*W)'(v);
          r  = ref_op(op, vv[2*W-1:W], vv[W-1:0]);
          sb_q.push_back({&r, r});
        end
      end
      if (sweep_done) done_cnt++;
      if (chk_busy_ready) check_eq("in_ready_during_sweep", in_ready, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (sweep_done) break;
    end
    check_eq("sweep_done_seen", sweep_done, 1);
    chk_busy_ready = 0;
  endtask

  task automatic start_sweep(input logic [2:0] o);
    op = o;
    sw_eff = 1;
    sweep_start = 1;
    step();
    sweep_start = 0;
    sw_eff = 0;
    chk_busy_ready = 1;
    check_eq("sweep_busy_after_start", sweep_busy, 1);
  endtask

  initial begin
    reset = 1; op = 0; a = 0; b = 0; in_valid = 0; out_ready = 0; sweep_start = 0;
    step();
    step();
    check_eq("rst_s", s, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_all_ones", all_ones, 0);
    check_eq("rst_match_cnt", match_cnt, 0);
    check_eq("rst_busy", sweep_busy, 0);
    check_eq("rst_done", sweep_done, 0);
    reset = 0;
    #1;
    check_eq("rst_in_ready", in_ready, 1);

    // XNOR of equal operands gives all ones, one-cycle latency
    out_ready = 1; op = 3'b011; a = 4'b1010; b = 4'b1010; in_valid = 1;
    step();
    in_valid = 0;
    check_eq("xnor_s", s, 4'b1111);
    check_eq("xnor_all_ones", all_ones, 1);
    check_eq("xnor_out_valid", out_valid, 1);
    step();
    check_eq("xnor_match_cnt", match_cnt, 1);

    // AND result held under back-pressure
    out_ready = 0; op = 3'b000; a = 4'b1100; b = 4'b1010; in_valid = 1;
    step();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check_eq("hold_s", s, 4'b1000);
      check_eq("hold_out_valid", out_valid, 1);
      check_eq("hold_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1;
    #1;
    check_eq("release_in_ready", in_ready, 1);
    step();

    // Random beats with random back-pressure
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      step();
    end
    in_valid = 0; out_ready = 1;
    repeat (3) step();

    // Full XNOR sweep: 16 matches (a == b)
    start_sweep(3'b011);
    wait_done(NV + 20);
    step();
    check_eq("xnor_sweep_busy_clear", sweep_busy, 0);
    check_eq("xnor_sweep_done_clear", sweep_done, 0);
    check_eq("xnor_sweep_match", match_cnt, 16);
    check_eq("xnor_sweep_done_cnt", done_cnt, 1);
    check_eq("xnor_sweep_sb_empty", sb_q.size(), 0);

    // OR sweep behind a pending result, toggling out_ready, ignored restart
    out_ready = 0; op = 3'b110; a = 4'b0101; in_valid = 1;
    step();
    in_valid = 0;
    start_sweep(3'b001);
    for (int i = 0; i < 3 * NV; i++) begin
      out_ready = ~out_ready;
      sweep_start = (i == 50);
      op = 3'b000;
      in_valid = (i % 3 == 0);
      step();
      if (sweep_done) break;
    end
    sweep_start = 0; in_valid = 0;
    check_eq("or_sweep_done_seen", sweep_done, 1);
    chk_busy_ready = 0;
    step();
    check_eq("or_sweep_busy_clear", sweep_busy, 0);
    check_eq("or_sweep_done_cnt", done_cnt, 2);
    check_eq("or_sweep_sb_empty", sb_q.size(), 0);

    // Reset in the middle of an AND sweep
    out_ready = 1;
    start_sweep(3'b000);
    repeat (5) step();
    chk_busy_ready = 0;
    reset = 1;
    step();
    reset = 0;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_match_cnt", match_cnt, 0);
    check_eq("midrst_busy", sweep_busy, 0);
    check_eq("midrst_done", sweep_done, 0);
    repeat (5) step();
    check_eq("midrst_no_done_pulse", done_cnt, 2);

    // Saturation of match_cnt with pass-a of all ones
    op = 3'b111; a = '1; b = 4'b0011; in_valid = 1; out_ready = 1;
    repeat (CMAX + 8) step();
    in_valid = 0;
    repeat (2) step();
    check_eq("sat_match_cnt", match_cnt, CMAX);
    check_eq("sat_sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
